// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: arbiter FSM states and add/sub opcodes
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response handshake bundle for the shared ALU
interface alu_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_overflow;
    logic [1:0]       ovf_sticky;
    logic [1:0]       ovf_clear;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp0_ready, rsp1_ready, ovf_clear,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_overflow, ovf_sticky
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp0_ready, rsp1_ready, ovf_clear,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_overflow, ovf_sticky
    );

endinterface

// File: rtl/add_sub_ovf.sv
// rtl/add_sub_ovf.sv - combinational two's-complement add/sub with signed overflow
module add_sub_ovf
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] cin;

    always_comb begin
        b_eff = (sub == OP_SUB) ? ~b : b;
        cin   = {{(WIDTH-1){1'b0}}, sub};
        sum   = a + b_eff + cin;
        // Overflow: operands agree in sign but the result does not.
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one add/sub unit between two requesters
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       sticky_q, sticky_d;

    logic             grant;
    logic             any_valid;
    logic [1:0]       ready;
    logic [1:0]       set_mask;
    logic             rsp_ready_sel;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    add_sub_ovf #(.WIDTH(WIDTH)) u_add_sub_ovf (
        .a   (a_q),
        .b   (b_q),
        .sub (sub_q),
        .sum (sum),
        .ovf (sum_ovf)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        a_d           = a_q;
        b_d           = b_q;
        sub_d         = sub_q;
        result_d      = result_q;
        ovf_d         = ovf_q;
        ready         = 2'b00;
        set_mask      = 2'b00;
        any_valid     = bus.req0_valid || bus.req1_valid;
        // On a tie the requester that did not win last time goes next.
        grant         = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : ~bus.req0_valid;
        rsp_ready_sel = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

        case (state_q)
            IDLE: begin
                if (any_valid && rst_n) begin
                    ready[grant] = 1'b1;
                    owner_d      = grant;
                    last_grant_d = grant;
                    a_d          = grant ? bus.req1_a   : bus.req0_a;
                    b_d          = grant ? bus.req1_b   : bus.req0_b;
                    sub_d        = grant ? bus.req1_sub : bus.req0_sub;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d          = sum;
                ovf_d             = sum_ovf;
                set_mask[owner_q] = sum_ovf;
                state_d           = RESP;
            end
            RESP: begin
                if (rsp_ready_sel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set beats clear when both land on the same bit in one cycle.
        sticky_d = (sticky_q & ~bus.ovf_clear) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            sticky_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sub_q        <= sub_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            sticky_q     <= sticky_d;
        end
    end

    assign bus.req0_ready   = ready[0];
    assign bus.req1_ready   = ready[1];
    assign bus.rsp0_valid   = (state_q == RESP) && !owner_q;
    assign bus.rsp1_valid   = (state_q == RESP) &&  owner_q;
    assign bus.rsp_result   = result_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed checks against a transaction-level model
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(8)) bus ();
    alu_share_arbiter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction model: an op is busy from accept until its response is consumed.
    bit         m_busy;
    int         m_age;
    bit         m_owner;
    bit         m_last;
    logic [7:0] m_res;
    bit         m_ovf;
    logic [1:0] m_sticky;
    int         n_acc;
    int         n_rsp;
    int         grants[$];

    function automatic void model_reset();
        m_busy   = 0;
        m_age    = 0;
        m_last   = 1;
        m_sticky = 2'b00;
    endfunction

    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                   output logic [7:0] r, output bit o);
        int s;
        s = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        r = s[7:0];
        o = (s > 127) || (s < -128);
    endfunction

    task automatic step(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic s0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic s1,
                        input logic rr0, input logic rr1, input logic [1:0] clr);
        logic [1:0] exp_rdy;
        logic [1:0] exp_rsp;
        logic [1:0] set;
        int         g;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_sub = s0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_sub = s1;
        bus.rsp0_ready = rr0; bus.rsp1_ready = rr1; bus.ovf_clear = clr;
        #2;
        exp_rdy = 2'b00;
        g = 0;
        if (!m_busy && (v0 || v1)) begin
            g = (v0 && v1) ? (m_last ? 0 : 1) : (v0 ? 0 : 1);
            exp_rdy[g] = 1'b1;
        end
        exp_rsp = 2'b00;
        if (m_busy && m_age >= 1) exp_rsp[m_owner] = 1'b1;
        check_eq("req0_ready", bus.req0_ready, exp_rdy[0]);
        check_eq("req1_ready", bus.req1_ready, exp_rdy[1]);
        check_eq("rsp0_valid", bus.rsp0_valid, exp_rsp[0]);
        check_eq("rsp1_valid", bus.rsp1_valid, exp_rsp[1]);
        check_eq("ovf_sticky", bus.ovf_sticky, m_sticky);
        if (exp_rsp != 2'b00) begin
            check_eq("rsp_result", bus.rsp_result, m_res);
            check_eq("rsp_overflow", bus.rsp_overflow, m_ovf);
        end
        if (bus.req0_ready && v0) grants.push_back(0);
        else if (bus.req1_ready && v1) grants.push_back(1);
        if ((bus.rsp0_valid && rr0) || (bus.rsp1_valid && rr1)) n_rsp++;
        @(posedge clk);
        #1;
        set = 2'b00;
        if (!m_busy) begin
            if (exp_rdy != 2'b00) begin
                if (g == 0) ref_op(a0, b0, s0, m_res, m_ovf);
                else        ref_op(a1, b1, s1, m_res, m_ovf);
                m_busy  = 1;
                m_age   = 0;
                m_owner = (g == 1);
                m_last  = (g == 1);
                n_acc++;
            end
        end else if (m_age == 0) begin
            m_age = 1;
            if (m_ovf) set[m_owner] = 1'b1;
        end else if (m_owner ? rr1 : rr0) begin
            m_busy = 0;
        end
        m_sticky = (m_sticky & ~clr) | set;
    endtask

    task automatic idle(input logic rr0, input logic rr1, input logic [1:0] clr);
        step(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, rr0, rr1, clr);
    endtask

    task automatic run_op(input string tag, input int who, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [1:0] clr_cap,
                          input logic [7:0] exp_res, input logic exp_ovf);
        if (who == 0) step(1, a, b, sub, 0, 8'h00, 8'h00, 0, 0, 0, 2'b00);
        else          step(0, 8'h00, 8'h00, 0, 1, a, b, sub, 0, 0, 2'b00);
        check_eq({tag, "_exec_valid"}, who ? bus.rsp1_valid : bus.rsp0_valid, 1'b0);
        idle(0, 0, clr_cap);
        check_eq({tag, "_valid"}, who ? bus.rsp1_valid : bus.rsp0_valid, 1'b1);
        check_eq({tag, "_res"}, bus.rsp_result, exp_res);
        check_eq({tag, "_ovf"}, bus.rsp_overflow, exp_ovf);
        idle(1, 1, 2'b00);
    endtask

    task automatic pulse_reset(input string tag);
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1 rst_n = 1'b0;
        #1;
        check_eq({tag, "_rdy0"}, bus.req0_ready, 1'b0);
        check_eq({tag, "_rdy1"}, bus.req1_ready, 1'b0);
        check_eq({tag, "_rspv"}, {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        check_eq({tag, "_res"}, bus.rsp_result, 8'h00);
        check_eq({tag, "_ovf"}, bus.rsp_overflow, 1'b0);
        check_eq({tag, "_sticky"}, bus.ovf_sticky, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b1;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_sub = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_sub = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0; bus.ovf_clear = 0;
        n_acc = 0; n_rsp = 0;
        model_reset();
        @(posedge clk);
        pulse_reset("reset");

        run_op("t1", 0, 8'h7F, 8'h01, 1'b0, 2'b00, 8'h80, 1'b1);
        check_eq("t1_sticky", bus.ovf_sticky, 2'b01);
        run_op("t2a", 1, 8'h80, 8'h01, 1'b1, 2'b00, 8'h7F, 1'b1);
        run_op("t2b", 1, 8'h00, 8'h80, 1'b1, 2'b00, 8'h80, 1'b1);
        run_op("t2c", 1, 8'h05, 8'h03, 1'b1, 2'b00, 8'h02, 1'b0);
        check_eq("t2_sticky", bus.ovf_sticky, 2'b11);
        idle(0, 0, 2'b11);
        check_eq("clr_sticky", bus.ovf_sticky, 2'b00);

        run_op("t6", 0, 8'h7F, 8'h01, 1'b0, 2'b01, 8'h80, 1'b1);
        check_eq("t6_set_wins", bus.ovf_sticky, 2'b01);
        idle(0, 0, 2'b01);
        check_eq("t6_cleared", bus.ovf_sticky, 2'b00);

        step(1, 8'h40, 8'h40, 0, 0, 8'h00, 8'h00, 0, 0, 0, 2'b00);
        idle(0, 0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h11, 8'h22, 0, 1, 8'h33, 8'h44, 1, 0, 0, 2'b00);
            check_eq("t4_hold_valid", bus.rsp0_valid, 1'b1);
            check_eq("t4_hold_res", bus.rsp_result, 8'h80);
            check_eq("t4_hold_ovf", bus.rsp_overflow, 1'b1);
        end
        idle(1, 0, 2'b00);

        pulse_reset("t3_rst");
        grants.delete();
        for (int i = 0; i < 12; i++)
            step(1, 8'($urandom), 8'($urandom), 1'($urandom), 1, 8'($urandom), 8'($urandom), 1'($urandom), 1, 1, 2'b00);
        check_eq("t3_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_eq("t3_grant", grants[i], i % 2);

        idle(1, 1, 2'b00);
        step(1, 8'h7F, 8'h7F, 0, 0, 8'h00, 8'h00, 0, 0, 0, 2'b00);
        pulse_reset("t5");
        step(1, 8'h01, 8'h01, 0, 1, 8'h02, 8'h02, 0, 1, 1, 2'b00);
        check_eq("t5_no_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        idle(1, 1, 2'b00);
        idle(1, 1, 2'b00);

        n_acc = 0; n_rsp = 0;
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00);
        for (int i = 0; i < 4; i++) idle(1, 1, 2'b00);
        check_eq("rand_no_loss", n_rsp, n_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
